song_sequencer: RTL
===================

Name: song_sequencer

Overview:
- Plays a song out of the registered note ROM: one 5-bit lane mask per step, one-cycle read latency, 8-bit address.
- Owns the ROM address and steps it at a fixed tempo.
- Maintains a scrolling window of upcoming note rows for the display and the hit-detection logic.
- Provides start, pause, resume and end-of-song control for the game FSM.

Parameters:
- TICKS_PER_STEP, 12500000, clk cycles per song step (4 steps/s at 50 MHz); must be >= 2.
- SONG_LEN, 94, number of ROM entries played, addresses 0..SONG_LEN-1; must be <= 256.
- LOOKAHEAD, 8, rows in the scroll window; row 0 is the hit line, row LOOKAHEAD-1 is the newest row.
- LANES, 5, lane-mask width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: start from IDLE/DONE, resume from PAUSED
- pause  in  1  one-cycle pulse: pause from RUN, resume from PAUSED
- rom_addr  out  8  drives the note ROM address (go)
- rom_data  in  LANES  note ROM output, valid one cycle after rom_addr changes
- window  out  LANES*LOOKAHEAD  scroll window; row i at bits [i*LANES +: LANES]
- hit_row  out  LANES  equals window row 0
- step_strobe  out  1  high for one cycle on the edge where the window shifts
- step_count  out  9  steps performed since start
- state  out  2  IDLE=0, RUN=1, PAUSED=2, DONE=3
- song_done  out  1  high while in DONE

Behaviour:
- Reset: state=IDLE, rom_addr=0, window=0, tick_cnt=0, step_count=0, step_strobe=0, song_done=0. Reset mid-song returns to IDLE on the next edge.
- IDLE:
  - start -> RUN; window, tick_cnt, step_count and rom_addr cleared on that edge.
  - pause ignored.
- RUN, timing:
  - tick_cnt increments every cycle.
  - When tick_cnt == TICKS_PER_STEP-1 (step event): tick_cnt <= 0.
  - First step occurs TICKS_PER_STEP cycles after the start edge.
- RUN, step event, all on the same edge:
  - row[i] <= row[i+1] for i < LOOKAHEAD-1.
  - row[LOOKAHEAD-1] <= rom_data if rom_addr < SONG_LEN, else 0.
  - rom_addr <= rom_addr+1, saturating at SONG_LEN.
  - step_count++.
  - step_strobe=1 for that cycle.
- ROM latency: rom_addr is stable for >= 2 cycles before each step, so rom_data always matches rom_addr when sampled.
- A note fetched at step k appears at row 0 on step k+LOOKAHEAD-1 and leaves the window at step k+LOOKAHEAD.
- End of song:
  - On the step where step_count becomes SONG_LEN+LOOKAHEAD: state <= DONE, song_done=1.
  - Window is all zero at that point.
  - rom_addr holds at SONG_LEN.
- RUN + pause -> PAUSED:
  - tick_cnt, window, rom_addr and step_count frozen.
  - If pause coincides with a step event, pause wins: the step is suppressed and tick_cnt holds at TICKS_PER_STEP-1.
  - The suppressed step then fires on the first RUN cycle after resume.
- start while in RUN is ignored.
- PAUSED:
  - start or pause -> RUN; counting resumes from the frozen tick_cnt.
  - Both asserted together -> RUN.
- DONE:
  - Outputs hold.
  - start restarts exactly as from IDLE.
  - pause ignored.
- step_strobe is 0 in every cycle without a step event.

Decomposition:
- Package song_pkg:
  - LANES.
  - Default SONG_LEN.
  - note_t (logic [LANES-1:0]).
  - state_t enum {IDLE, RUN, PAUSED, DONE} with the encodings above.
- Sub-module step_timer:
  - Inputs: clk, reset, en, clr.
  - Behaviour: counts to TICKS_PER_STEP-1 and pulses tick.
  - Holds its count while en=0; clr zeroes the count.
  - The sequencer drives en = (state==RUN) && !pause.

Test Plan (bench parameters TICKS_PER_STEP=4, SONG_LEN=10, LOOKAHEAD=4; behavioural ROM with 1-cycle latency, ROM[a]=a[4:0]+1):
- Reset then start pulse.
  - First step_strobe 4 cycles after the start edge.
  - Window row3=5'h01, rom_addr=1.
  - After 4 steps, hit_row=5'h01.
- Run to completion.
  - Exactly 14 step_strobes.
  - state=DONE, song_done=1, window=0, rom_addr=10, step_count=14.
  - No further strobes over 40 idle cycles.
- Pause asserted on the cycle tick_cnt==3 of step 2.
  - No strobe that cycle; window frozen for 20 cycles.
  - On resume, strobe on the first RUN cycle; step_count=3.
- Mid-song reset after step 5.
  - Next edge: state=IDLE, window=0, rom_addr=0, step_count=0.
  - Start then replays from ROM[0].
- start during RUN has no effect.
  - start in DONE restarts: step_count=0, first strobe after 4 cycles, row3=5'h01.
- Simultaneous start+pause in PAUSED resumes to RUN; pause alone in IDLE leaves state=IDLE.

Source files
------------

// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer: lane width, default
// song length, note row type and the player state encoding.
package song_pkg;

  localparam int LANES            = 5;
  localparam int SONG_LEN_DEFAULT = 94;

  typedef logic [LANES-1:0] note_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/song_sequencer_step_timer.sv
// Tempo divider: counts enabled cycles and flags the last cycle of each step.
// The count freezes while en is low, so a paused step resumes where it left off.
module step_timer #(
  parameter int TICKS_PER_STEP = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICKS_PER_STEP);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);

  logic [CW-1:0] cnt_r;

  // tick is only meaningful when the count is allowed to advance
  assign tick = en && (cnt_r == LAST);

  // Tick counter with clear priority over enable
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Song player: steps the note ROM address at a fixed tempo and keeps a
// scrolling window of upcoming rows, with start/pause/resume control.
module song_sequencer
  import song_pkg::*;
#(
  parameter int TICKS_PER_STEP = 12500000,
  parameter int SONG_LEN       = SONG_LEN_DEFAULT,
  parameter int LOOKAHEAD      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       pause,
  output logic [7:0]                 rom_addr,
  input  logic [LANES-1:0]           rom_data,
  output logic [LANES*LOOKAHEAD-1:0] window,
  output logic [LANES-1:0]           hit_row,
  output logic                       step_strobe,
  output logic [8:0]                 step_count,
  output logic [1:0]                 state,
  output logic                       song_done
);

  localparam int WW = LANES * LOOKAHEAD;
  localparam logic [8:0] SONG_LEN_W = 9'(SONG_LEN);
  localparam logic [8:0] END_COUNT  = 9'(SONG_LEN + LOOKAHEAD);

  state_t        state_r;
  logic [8:0]    addr_r;
  logic [WW-1:0] window_r;
  logic [8:0]    count_r;
  logic          strobe_r;
  logic          done_r;

  logic  tick_s;
  logic  en_s;
  logic  clr_s;
  note_t new_row_s;

  step_timer #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .en   (en_s),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Timer control and the row entering the top of the window
  always_comb begin
    en_s      = (state_r == RUN) && !pause;
    clr_s     = ((state_r == IDLE) || (state_r == DONE)) && start;
    new_row_s = {LANES{1'b0}};
    // addr_r is 9 bits so saturation at SONG_LEN==256 stays representable
    if (addr_r < SONG_LEN_W) begin
      new_row_s = rom_data;
    end else begin
      new_row_s = {LANES{1'b0}};
    end
  end

  // Player state, window shift and step bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      addr_r   <= 9'd0;
      window_r <= {WW{1'b0}};
      count_r  <= 9'd0;
      strobe_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      strobe_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r  <= RUN;
            addr_r   <= 9'd0;
            window_r <= {WW{1'b0}};
            count_r  <= 9'd0;
            done_r   <= 1'b0;
          end
        end
        RUN: begin
          // pause wins over a coincident step; the timer holds at its last tick
          if (pause) begin
            state_r <= PAUSED;
          end else if (tick_s) begin
            window_r <= {new_row_s, window_r[WW-1:LANES]};
            if (addr_r < SONG_LEN_W) begin
              addr_r <= addr_r + 9'd1;
            end
            count_r  <= count_r + 9'd1;
            strobe_r <= 1'b1;
            if ((count_r + 9'd1) == END_COUNT) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end
        end
        PAUSED: begin
          if (start || pause) begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign rom_addr    = addr_r[7:0];
  assign window      = window_r;
  assign hit_row     = window_r[LANES-1:0];
  assign step_strobe = strobe_r;
  assign step_count  = count_r;
  assign state       = state_r;
  assign song_done   = done_r;

endmodule
